i2c_slave_rx: RTL and testbench

I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

---
 rtl/i2c_slave_rx.sv | 133 +++++++++++++
 tb/tb_i2c_slave_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target receiver: synchronizes SCL/SDA, decodes START/STOP,
// matches the 7-bit address, ACKs writes and delivers received data bytes.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1010000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

  state_t     state;
  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic [6:0] shreg;
  logic [2:0] cnt;
  logic       ack_on;

  logic       scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] byte_c;

  // Two-flop synchronizers plus a history flop; reset to the idle bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise = scl_s2 & ~scl_d;
  assign scl_fall = ~scl_s2 & scl_d;
  assign start_c  = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_c   = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign byte_c   = {shreg, sda_s2};

  // Protocol FSM; STOP outranks START, START outranks everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      stop_det <= 1'b0;
      shreg    <= 7'd0;
      cnt      <= 3'd0;
      ack_on   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      stop_det <= 1'b0;
      if (stop_c) begin
        state    <= IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        stop_det <= 1'b1;
        cnt      <= 3'd0;
        ack_on   <= 1'b0;
      end else if (start_c) begin
        state  <= ADDR;
        sda_oe <= 1'b0;
        cnt    <= 3'd0;
        ack_on <= 1'b0;
      end else begin
        case (state)
          ADDR, DATA: begin
            if (scl_rise) begin
              shreg <= byte_c[6:0];
              cnt   <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                if (state == ADDR) begin
                  if (byte_c[7:1] == SLAVE_ADDR && !byte_c[0]) begin
                    state <= ADDR_ACK;
                    busy  <= 1'b1;
                  end else begin
                    state <= IGNORE;
                    busy  <= 1'b0;
                  end
                end else begin
                  rx_data  <= byte_c;
                  rx_valid <= 1'b1;
                  state    <= DATA_ACK;
                end
              end
            end
          end
          // First SCL fall ends bit 8 (pull SDA), second ends the 9th clock.
          ADDR_ACK, DATA_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                ack_on <= 1'b0;
                cnt    <= 3'd0;
                state  <= DATA;
              end
            end
          end
          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Scoreboard bench for i2c_slave_rx: directed I2C master tasks push expected
// bytes; a monitor pops and compares on every rx_valid pulse.
`timescale 1ns/1ps
module tb_i2c_slave_rx;

  localparam int unsigned Q = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       stop_det;
  logic       sda_line;

  int         checks = 0;
  int         errors = 0;
  int         sd_cnt = 0;
  int         sd_before;
  logic       rv_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic       seen;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_rx #(.SLAVE_ADDR(7'b1010000)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl_m),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .stop_det (stop_det)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b0; #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    #(Q);
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic ack_slot(input string name, input logic exp);
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(Q);
    chk(name, 32'(sda_oe), 32'(exp));
    #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b1; #(2*Q);
  endtask

  // Scoreboard monitor: every rx_valid must match the oldest expected byte.
  always @(negedge clk) begin
    if (stop_det) sd_cnt++;
    if (rx_valid) begin
      chk("rx_valid_width", 32'(rv_prev), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %0h expected none at %0t", rx_data, $time);
      end else begin
        chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
    rv_prev <= rx_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stop_det", 32'(stop_det), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single write 0x50/W, 0xAC
    sd_before = sd_cnt;
    i2c_start();
    send_byte(8'hA0);
    ack_slot("t1_addr_ack", 1'b1);
    chk("t1_busy", 32'(busy), 32'd1);
    exp_q.push_back(8'hAC);
    send_byte(8'hAC);
    ack_slot("t1_data_ack", 1'b1);
    i2c_stop();
    chk("t1_stop_det", 32'(sd_cnt - sd_before), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // Wrong address 0x51/W: ignored
    i2c_start();
    send_byte(8'hA2);
    ack_slot("t2_addr_nack", 1'b0);
    chk("t2_busy", 32'(busy), 32'd0);
    send_byte(8'h12);
    ack_slot("t2_data_nack", 1'b0);
    i2c_stop();

    // Read request 0x50/R: NACK
    i2c_start();
    send_byte(8'hA1);
    ack_slot("t3_read_nack", 1'b0);
    chk("t3_busy", 32'(busy), 32'd0);
    i2c_stop();

    // Burst write 0xAC, 0x35
    i2c_start();
    send_byte(8'hA0);
    ack_slot("t4_addr_ack", 1'b1);
    exp_q.push_back(8'hAC);
    send_byte(8'hAC);
    ack_slot("t4_ack1", 1'b1);
    exp_q.push_back(8'h35);
    send_byte(8'h35);
    ack_slot("t4_ack2", 1'b1);
    i2c_stop();

    // STOP after 4 data bits, then a fresh transfer of 0x0F
    i2c_start();
    send_byte(8'hA0);
    ack_slot("t5_addr_ack", 1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop();
    chk("t5_busy_after_abort", 32'(busy), 32'd0);
    i2c_start();
    send_byte(8'hA0);
    ack_slot("t5_addr_ack2", 1'b1);
    exp_q.push_back(8'h0F);
    send_byte(8'h0F);
    ack_slot("t5_data_ack", 1'b1);
    i2c_stop();

    // Reset during the data-byte ACK, then a clean transfer
    i2c_start();
    send_byte(8'hA0);
    ack_slot("t6_addr_ack", 1'b1);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (sda_oe) seen = 1'b1;
      else @(negedge clk);
    end
    chk("t6_oe_before_rst", 32'(seen), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_oe_next_clk", 32'(sda_oe), 32'd0);
    @(negedge clk);
    chk("t6_rst_rx_data", 32'(rx_data), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_rx_valid", 32'(rx_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    ack_slot("t6_post_rst_slot", 1'b0);
    i2c_stop();
    i2c_start();
    send_byte(8'hA0);
    ack_slot("t6_addr_ack2", 1'b1);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C);
    ack_slot("t6_data_ack2", 1'b1);
    i2c_stop();

    repeat (10) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("stop_total", 32'(sd_cnt), 32'd8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
